ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative integer multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline latch. It takes the latched register operands and a mul/div opcode and runs a 32-iteration shift-add or restoring-divide sequence. It writes the architectural HI/LO registers and holds `busy` so the hazard logic stalls ID/EX while an operation is in flight.

## Interface
- No parameters. Operand width is fixed at 32 bits (`word_t`).
- `CLK  in  1`: core clock; all state updates on the rising edge.
- `nRST  in  1`: asynchronous, active-low reset.
- `start  in  1`: valid mul/div/move op presented from the ID/EX latch this cycle.
- `op  in  3`: operation select.
  - `000` MULT, `001` MULTU, `010` DIV, `011` DIVU, `100` MTHI, `101` MTLO.
  - `110` and `111` are ignored.
- `rs_i  in  32`: first operand: multiplicand, dividend, or MTHI/MTLO source.
- `rt_i  in  32`: second operand: multiplier or divisor.
- `flush  in  1`: squash the in-flight operation (branch/jump redirect).
- `busy  out  1`: high while state is not IDLE.
- `done  out  1`: one-cycle pulse when HI/LO take a mul/div result.
- `hi_o  out  32`: HI register contents. EX muxes this for MFHI.
- `lo_o  out  32`: LO register contents. EX muxes this for MFLO.

## Operation
- States:
  - IDLE: wait for an op.
  - RUN: 32 iterations, with a 5-bit counter running 0..31.
  - FIX: sign correction and HI/LO write.
- IDLE transitions (evaluated at the clock edge):
  - `start` with op MULT/MULTU/DIV/DIVU: latch operand magnitudes and result-sign flags, clear the counter, go to RUN.
  - `start` with op MTHI/MTLO: write HI or LO with `rs_i` on that edge. Stay in IDLE, no `busy`, no `done`.
- RUN behaviour:
  - Multiply: 64-bit `{acc, mplier}` shift-add on unsigned magnitudes.
  - Divide: restoring division on magnitudes with a 33-bit partial remainder. One quotient bit per cycle.
  - When counter = 31, go to FIX.
- FIX behaviour:
  - Negate the product if the operand signs differ (signed ops only).
  - Negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write {HI,LO}, pulse `done`, go to IDLE.
- Result mapping:
  - MULT/MULTU: HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero (signed or unsigned): HI = `rs_i`, LO = 0xFFFFFFFF. Full latency applies.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `start` while `busy`: ignored. Upstream stalls on `busy`; the bench flags this as an error.
- `flush`:
  - In RUN or FIX: go to IDLE on the next edge. HI/LO unchanged, no `done`.
  - With `start` in the same cycle: `flush` wins and the op is dropped.
- Undefined ops (`110`/`111`) are ignored.

## Timing
- Reset values (asynchronous, immediate on `nRST` low): state IDLE, counter 0, HI = LO = 0, `busy` = 0, `done` = 0.
- Reset mid-operation aborts immediately, with the same values as above.
- Mul/div sequence, with `start` sampled at edge E0:
  - `busy` is high from after E0 until E33.
  - RUN covers edges E1..E32.
  - FIX writes HI/LO at E33.
  - `done` is high for the one cycle after E33, the same cycle the new `hi_o`/`lo_o` are visible.
- Start-to-result latency is 33 cycles.
- MTHI/MTLO: the new value is visible on `hi_o`/`lo_o` the cycle after the edge that samples `start`.
- Back-to-back ops: a new `start` is accepted in the `done` cycle (state is IDLE). No bubble is required.
- `hi_o`, `lo_o`, `busy` and `done` are all registered or decoded from registered state. No combinational path runs from inputs to outputs.

## Configuration
- `EX_MULDIV_DIV_EN` defined:
  - Divider datapath and DIV/DIVU are implemented as described above.
- `EX_MULDIV_DIV_EN` not defined:
  - Divider logic is removed.
  - DIV/DIVU are treated as undefined ops: no state change, no `busy`, no `done`, HI/LO unchanged.
  - Multiply and MTHI/MTLO are unaffected.

## Test plan
- MULT, rs = 0xFFFFFFFE, rt = 3 -> `busy` for 33 cycles, `done` pulse, HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- MULTU, 0xFFFFFFFF × 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001. A second MULT issued in the `done` cycle is accepted.
- DIV, −7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Then DIVU 7 / 0 -> HI = 0x00000007, LO = 0xFFFFFFFF.
- MTHI 0x1234, MTLO 0x5678, then MULT with `flush` raised at RUN cycle 10:
  - `busy` drops the next cycle and no `done` appears.
  - HI = 0x1234, LO = 0x5678.
- `nRST` pulsed low at RUN cycle 20 -> `busy` = 0 and HI = LO = 0 immediately. The next MULT 5 × 6 gives LO = 30.
- Build without `EX_MULDIV_DIV_EN`, issue DIV -> `busy` and `done` stay 0 and HI/LO are unchanged.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Divider datapath and DIV/DIVU are built only when EX_MULDIV_DIV_EN is defined.
module ex_muldiv (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_e;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [32:0] acc_q;
  word_t       q_q, b_q, hi_q, lo_q;
  logic        neg_q, done_q;
`ifdef EX_MULDIV_DIV_EN
  localparam logic [2:0] OP_DIVU = 3'b011;
  logic        is_div_q, neg_rem_q, dvz_q;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
`endif

  logic        signed_op, is_md_op;
  word_t       rs_mag, rt_mag;
  logic [32:0] mul_sum, acc_step;
  word_t       q_step, res_hi, res_lo;
  logic [63:0] prod_mag, prod_fix;

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    is_md_op  = (op == OP_MULT) || (op == OP_MULTU);
`ifdef EX_MULDIV_DIV_EN
    is_md_op  = is_md_op || (op == OP_DIV) || (op == OP_DIVU);
`endif
    rs_mag = (signed_op && rs_i[31]) ? word_t'(-rs_i) : rs_i;
    rt_mag = (signed_op && rt_i[31]) ? word_t'(-rt_i) : rt_i;
  end

  // One iteration. Multiply: q_q is the low half of {acc, mplier}, b_q the addend.
  // Divide: q_q shifts dividend bits out and quotient bits in, b_q is the divisor.
  always_comb begin
    mul_sum  = {1'b0, acc_q[31:0]} + (q_q[0] ? {1'b0, b_q} : 33'd0);
    acc_step = {1'b0, mul_sum[32:1]};
    q_step   = {mul_sum[0], q_q[31:1]};
`ifdef EX_MULDIV_DIV_EN
    div_shift = {acc_q[31:0], q_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    if (is_div_q) begin
      if (!div_diff[33]) begin
        acc_step = div_diff[32:0];
        q_step   = {q_q[30:0], 1'b1};
      end else begin
        acc_step = div_shift;
        q_step   = {q_q[30:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    prod_mag = {acc_q[31:0], q_q};
    prod_fix = neg_q ? 64'(-prod_mag) : prod_mag;
    res_hi   = prod_fix[63:32];
    res_lo   = prod_fix[31:0];
`ifdef EX_MULDIV_DIV_EN
    // A zero divisor leaves |rs| in the remainder, so the signed fix restores rs.
    if (is_div_q) begin
      res_lo = dvz_q ? 32'hFFFF_FFFF : (neg_q ? word_t'(-q_q) : q_q);
      res_hi = neg_rem_q ? word_t'(-acc_q[31:0]) : acc_q[31:0];
    end
`endif
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= '0;
      q_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef EX_MULDIV_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      dvz_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              if (op == OP_MTHI) begin
                hi_q <= rs_i;
              end else if (op == OP_MTLO) begin
                lo_q <= rs_i;
              end else if (is_md_op) begin
                state_q   <= RUN;
                cnt_q     <= 5'd0;
                acc_q     <= '0;
                q_q       <= rs_mag;
                b_q       <= rt_mag;
                neg_q     <= signed_op && (rs_i[31] ^ rt_i[31]);
`ifdef EX_MULDIV_DIV_EN
                is_div_q  <= op[1];
                neg_rem_q <= signed_op && rs_i[31];
                dvz_q     <= (rt_i == 32'd0);
`endif
              end
            end
          end
          RUN: begin
            acc_q <= acc_step;
            q_q   <= q_step;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= FIX;
          end
          FIX: begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv; divide vectors run when EX_MULDIV_DIV_EN is defined,
// otherwise DIV is checked to be ignored.
module tb_ex_muldiv;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs_i = '0;
  logic [31:0] rt_i = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi_o, lo_o;

  int n_vec = 0;
  int n_err = 0;

  ex_muldiv dut (
    .CLK(CLK), .nRST(nRST), .start(start), .op(op), .rs_i(rs_i), .rt_i(rt_i),
    .flush(flush), .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge of the done cycle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int cycles;
    start = 1'b1; op = o; rs_i = a; rt_i = b;
    @(negedge CLK);
    start = 1'b0;
    check({tag, "_busy_on"}, {31'd0, busy}, 32'd1);
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge CLK);
    end
    check({tag, "_busy_cycles"}, 32'(cycles), 32'd33);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_hi"}, hi_o, exp_hi);
    check({tag, "_lo"}, lo_o, exp_lo);
  endtask

  initial begin
    int dones;
    repeat (2) @(negedge CLK);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    nRST = 1'b1;
    @(negedge CLK);

    run_op("mult_neg", 3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    @(negedge CLK);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    // Issued in the done cycle: 7 * -3 = -21
    run_op("mult_b2b", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    @(negedge CLK);

`ifdef EX_MULDIV_DIV_EN
    run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 3'b011, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("div_zero_neg", 3'b010, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
    run_op("divu_big", 3'b011, 32'hFFFF_FFFF, 32'd10, 32'h0000_0005, 32'h1999_9999);
    @(negedge CLK);
`else
    start = 1'b1; op = 3'b010; rs_i = 32'd100; rt_i = 32'd7;
    @(negedge CLK);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      check("nodiv_busy", {31'd0, busy}, 32'd0);
      if (done === 1'b1) dones++;
      @(negedge CLK);
    end
    check("nodiv_dones", 32'(dones), 32'd0);
    check("nodiv_hi", hi_o, 32'hFFFF_FFFF);
    check("nodiv_lo", lo_o, 32'hFFFF_FFEB);
`endif

    // Undefined opcode leaves everything alone
    start = 1'b1; op = 3'b110; rs_i = 32'hDEAD_BEEF; rt_i = 32'd1;
    @(negedge CLK);
    start = 1'b0;
    check("undef_busy", {31'd0, busy}, 32'd0);

    start = 1'b1; op = 3'b100; rs_i = 32'h0000_1234;
    @(negedge CLK);
    start = 1'b0;
    check("mthi_hi", hi_o, 32'h0000_1234);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);
    start = 1'b1; op = 3'b101; rs_i = 32'h0000_5678;
    @(negedge CLK);
    start = 1'b0;
    check("mtlo_lo", lo_o, 32'h0000_5678);
    check("mtlo_hi_kept", hi_o, 32'h0000_1234);

    // Flush in the same cycle as start drops the op
    start = 1'b1; flush = 1'b1; op = 3'b000; rs_i = 32'd9; rt_i = 32'd9;
    @(negedge CLK);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);

    start = 1'b1; op = 3'b000; rs_i = 32'd3; rt_i = 32'd4;
    @(negedge CLK);
    start = 1'b0;
    repeat (10) @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dones++;
      @(negedge CLK);
    end
    check("flush_dones", 32'(dones), 32'd0);
    check("flush_hi", hi_o, 32'h0000_1234);
    check("flush_lo", lo_o, 32'h0000_5678);

    start = 1'b1; op = 3'b001; rs_i = 32'd11; rt_i = 32'd13;
    @(negedge CLK);
    start = 1'b0;
    repeat (20) @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi_o, 32'd0);
    check("arst_lo", lo_o, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    run_op("mult_5x6", 3'b000, 32'd5, 32'd6, 32'd0, 32'd30);
    @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
